// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: turns the asynchronous 100 Hz divider square wave and two
// debounced buttons into single-cycle events. It runs the IDLE/RUN/PAUSE/LAP
// state machine and keeps an SS.CC BCD count plus a lap snapshot.
module stopwatch_ctrl #(
    parameter int SYNC_STAGES  = 2,  // at least 2
    parameter int SEC_MAX_TENS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_clk_in,
    input  logic        btn_start_stop,
    input  logic        btn_lap_clr,
    output logic [15:0] disp_bcd,
    output logic [1:0]  state,
    output logic        running,
    output logic        tick,
    output logic        wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    localparam int BOOT_W = $clog2(SYNC_STAGES + 1);

    // Input bit order: [0] div clock, [1] start/stop, [2] lap/clear
    logic [2:0]                  w_async;
    logic [2:0][SYNC_STAGES-1:0] r_sync;
    logic [2:0]                  w_synced;
    logic [2:0]                  r_prev;
    logic [2:0]                  r_armed;
    logic [2:0]                  w_evt;
    logic [BOOT_W-1:0]           r_boot;
    logic                        w_ready;

    state_t      r_state, w_nstate;
    logic [15:0] r_cnt, w_ncnt, w_cnt_inc;
    logic [15:0] r_lap, w_nlap;
    logic [15:0] r_disp;
    logic        r_wrap, w_nwrap;
    logic        w_roll, w_do_inc;
    logic        w_ss, w_lc;
    logic [3:0]  w_d0, w_d1, w_d2, w_d3;

    assign w_async = {btn_lap_clr, btn_start_stop, div_clk_in};
    assign w_ready = (r_boot == BOOT_W'(SYNC_STAGES));

    // Last stage of each synchroniser chain
    always_comb begin
        for (int i = 0; i < 3; i++) w_synced[i] = r_sync[i][SYNC_STAGES-1];
    end

    // Synchronisers, previous-value flops and arming. An input only becomes
    // armed once the flushed chain has shown it low. A level still held
    // across reset therefore needs a fresh rising edge to register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_prev  <= '0;
            r_armed <= '0;
            r_boot  <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_async[i]};
            r_prev  <= w_synced;
            r_armed <= r_armed | ({3{w_ready}} & ~w_synced);
            if (!w_ready) r_boot <= r_boot + BOOT_W'(1);
        end
    end

    assign w_evt = w_synced & ~r_prev & r_armed;
    assign tick  = w_evt[0];
    assign w_ss  = w_evt[1];
    assign w_lc  = w_evt[2];

    // BCD ripple increment of the live count; w_roll marks 59.99 -> 00.00
    always_comb begin
        {w_d3, w_d2, w_d1, w_d0} = r_cnt;
        w_roll = 1'b0;
        if (w_d0 != 4'd9) begin
            w_d0 = w_d0 + 4'd1;
        end else begin
            w_d0 = 4'd0;
            if (w_d1 != 4'd9) begin
                w_d1 = w_d1 + 4'd1;
            end else begin
                w_d1 = 4'd0;
                if (w_d2 != 4'd9) begin
                    w_d2 = w_d2 + 4'd1;
                end else begin
                    w_d2 = 4'd0;
                    if (w_d3 < 4'(SEC_MAX_TENS)) begin
                        w_d3 = w_d3 + 4'd1;
                    end else begin
                        w_d3   = 4'd0;
                        w_roll = 1'b1;
                    end
                end
            end
        end
        w_cnt_inc = {w_d3, w_d2, w_d1, w_d0};
    end

    // Next state, count and lap. The tick is judged against the old state,
    // and start/stop takes priority over a same-cycle lap/clear.
    always_comb begin
        w_do_inc = tick && (r_state == S_RUN || r_state == S_LAP);
        w_nstate = r_state;
        w_ncnt   = w_do_inc ? w_cnt_inc : r_cnt;
        w_nlap   = r_lap;
        w_nwrap  = w_do_inc & w_roll;
        case (r_state)
            S_IDLE: begin
                if (w_ss) w_nstate = S_RUN;
            end
            S_RUN: begin
                if (w_ss) begin
                    w_nstate = S_PAUSE;
                end else if (w_lc) begin
                    w_nstate = S_LAP;
                    w_nlap   = r_cnt;
                end
            end
            S_LAP: begin
                if (w_ss)      w_nstate = S_PAUSE;
                else if (w_lc) w_nstate = S_RUN;
            end
            S_PAUSE: begin
                if (w_ss) begin
                    w_nstate = S_RUN;
                end else if (w_lc) begin
                    w_nstate = S_IDLE;
                    w_ncnt   = '0;
                    w_nlap   = '0;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // State, count, lap, display and wrap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lap   <= '0;
            r_disp  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_lap   <= w_nlap;
            r_disp  <= (w_nstate == S_LAP) ? w_nlap : w_ncnt;
            r_wrap  <= w_nwrap;
        end
    end

    assign disp_bcd = r_disp;
    assign state    = r_state;
    assign running  = (r_state == S_RUN) || (r_state == S_LAP);
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl. Each row gives some ticks, optional
// presses, an optional tick aligned with the presses, and an optional
// async reset. Expected display and state go into a scoreboard queue and
// are compared once the DUT has settled.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_clk_in = 1'b0;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap_clr = 1'b0;
    logic [15:0] disp_bcd;
    logic [1:0]  state;
    logic        running, tick, wrap;

    stopwatch_ctrl #(.SYNC_STAGES(2), .SEC_MAX_TENS(5)) dut (
        .clk(clk), .rst_n(rst_n), .div_clk_in(div_clk_in),
        .btn_start_stop(btn_start_stop), .btn_lap_clr(btn_lap_clr),
        .disp_bcd(disp_bcd), .state(state), .running(running),
        .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          nt;
        int          half;
        bit          rst;
        bit          ss;
        bit          lc;
        bit          tk;
        logic [15:0] disp;
        logic [1:0]  st;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] disp;
        logic [1:0]  st;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick_cnt = 0, wrap_cnt = 0, wrap_bad = 0;

    // Count tick and wrap pulses, one per clk cycle they stay high
    always @(negedge clk) begin
        if (tick) tick_cnt++;
        if (wrap) begin
            wrap_cnt++;
            if (disp_bcd !== 16'h0000) wrap_bad++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input int nt, input int half, input bit rst,
                       input bit ss, input bit lc, input bit tk,
                       input logic [15:0] d, input logic [1:0] st);
        vec_t v;
        v.name = nm; v.nt = nt; v.half = half; v.rst = rst;
        v.ss = ss; v.lc = lc; v.tk = tk; v.disp = d; v.st = st;
        tbl.push_back(v);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk({e.name, "_disp"}, {16'h0, disp_bcd}, {16'h0, e.disp});
            chk({e.name, "_state"}, {30'h0, state}, {30'h0, e.st});
            chk({e.name, "_running"}, {31'h0, running},
                {31'h0, (e.st == 2'd1 || e.st == 2'd3)});
        end
    endtask

    // These tasks start and end at posedge+2ns
    task automatic do_tick(input int half);
        div_clk_in = 1'b1;
        repeat (half) @(posedge clk);
        #2 div_clk_in = 1'b0;
        repeat (half) @(posedge clk);
        #2;
    endtask

    task automatic press(input bit ss, input bit lc, input bit tk);
        btn_start_stop = ss;
        btn_lap_clr    = lc;
        if (tk) div_clk_in = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        btn_start_stop = 1'b0;
        btn_lap_clr    = 1'b0;
        div_clk_in     = 1'b0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    // Async reset pulse of one clk period, away from the clock edges, while
    // start/stop is being held. The held level must not count as a press.
    task automatic reset_seq();
        @(posedge clk);
        #3 rst_n = 1'b0;
        btn_start_stop = 1'b1;
        #1;
        chk("rst_async_disp", {16'h0, disp_bcd}, 32'h0);
        chk("rst_async_state", {30'h0, state}, 32'h0);
        chk("rst_async_running", {31'h0, running}, 32'h0);
        chk("rst_async_tick", {31'h0, tick}, 32'h0);
        chk("rst_async_wrap", {31'h0, wrap}, 32'h0);
        #9 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2 btn_start_stop = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    initial begin
        #1500us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        int   tbase, wbase;

        //  name          nt   half rst ss lc tk disp      st
        add("idle",        0,    3, 0, 0, 0, 0, 16'h0000, 2'd0);
        add("start",       0,    3, 0, 1, 0, 0, 16'h0000, 2'd1);
        add("run100",    100,   10, 0, 0, 0, 0, 16'h0100, 2'd1);
        add("to0347",    247,    3, 0, 0, 0, 0, 16'h0347, 2'd1);
        add("lap",         0,    3, 0, 0, 1, 0, 16'h0347, 2'd3);
        add("lap_hold",   50,    3, 0, 0, 0, 0, 16'h0347, 2'd3);
        add("lap_rel",     0,    3, 0, 0, 1, 0, 16'h0397, 2'd1);
        add("to1234",    837,    3, 0, 0, 0, 0, 16'h1234, 2'd1);
        add("pause",       0,    3, 0, 1, 0, 0, 16'h1234, 2'd2);
        add("pause_hold", 20,    3, 0, 0, 0, 0, 16'h1234, 2'd2);
        add("resume",      0,    3, 0, 1, 0, 0, 16'h1234, 2'd1);
        add("to4567",   3333,    3, 0, 0, 0, 0, 16'h4567, 2'd1);
        add("rst_held",    0,    3, 1, 0, 0, 0, 16'h0000, 2'd0);
        add("start2",      0,    3, 0, 1, 0, 0, 16'h0000, 2'd1);
        add("lap7",        7,    3, 0, 0, 1, 0, 16'h0007, 2'd3);
        add("lap_tk_ss",   3,    3, 0, 1, 0, 1, 16'h0011, 2'd2);
        add("run11",       0,    3, 0, 1, 0, 0, 16'h0011, 2'd1);
        add("run_tk_ss",   0,    3, 0, 1, 0, 1, 16'h0012, 2'd2);
        add("clear",       0,    3, 0, 0, 1, 0, 16'h0000, 2'd0);
        add("idle_lc",     0,    3, 0, 0, 1, 0, 16'h0000, 2'd0);
        add("idle_tk_ss",  0,    3, 0, 1, 0, 1, 16'h0000, 2'd1);
        add("both_btn",    5,    3, 0, 1, 1, 0, 16'h0005, 2'd2);
        add("pause_tk_lc", 0,    3, 0, 0, 1, 1, 16'h0000, 2'd0);
        add("start3",      0,    3, 0, 1, 0, 0, 16'h0000, 2'd1);
        add("to5999",   5999,    3, 0, 0, 0, 0, 16'h5999, 2'd1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_disp", {16'h0, disp_bcd}, 32'h0);
        chk("reset_state", {30'h0, state}, 32'h0);
        chk("reset_outs", {29'h0, running, tick, wrap}, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;

        tbase = tick_cnt;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.rst) reset_seq();
            for (int k = 0; k < v.nt; k++) do_tick(v.half);
            if (v.ss || v.lc || v.tk) press(v.ss, v.lc, v.tk);
            e.name = v.name; e.disp = v.disp; e.st = v.st;
            sbq.push_back(e);
            @(negedge clk);
            sb_check();
            if (i == 2) chk("tick_pulses_100", tick_cnt - tbase, 32'd100);
            @(posedge clk);
            #2;
        end

        // Roll over from 59.99: one wrap pulse, coinciding with 00.00
        chk("no_early_wrap", wrap_cnt, 32'd0);
        wbase = wrap_cnt;
        do_tick(3);
        e.name = "wrap_roll"; e.disp = 16'h0000; e.st = 2'd1;
        sbq.push_back(e);
        @(negedge clk);
        sb_check();
        chk("wrap_pulse_cycles", wrap_cnt - wbase, 32'd1);
        chk("wrap_with_zero", wrap_bad, 32'd0);
        do_tick(3);
        @(negedge clk);
        chk("post_wrap_count", {16'h0, disp_bcd}, 32'h0001);
        chk("wrap_no_repeat", wrap_cnt - wbase, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
